// File: rtl/vga_scandoubler.sv
// Line-doubling scan converter: 15.6 kHz RGB 3:3:2 in, 31 kHz VGA out.
// Two-bank line buffer: one bank is written at 7 MHz while the other is replayed twice at 14 MHz.
module vga_scandoubler #(
  parameter int BUF_AW       = 9,
  parameter int LINE_LEN_RST = 448,
  parameter int HS_START     = 329,
  parameter int HS_LEN       = 54
)(
  input  logic       rst_n,
  input  logic       clk28,
  input  logic       ck7,
  input  logic       ck14,
  input  logic       en,
  input  logic [8:0] hc_in,
  input  logic       even_line,
  input  logic [2:0] r_in,
  input  logic [2:0] g_in,
  input  logic [1:0] b_in,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       csync_in,
  output logic [2:0] r,
  output logic [2:0] g,
  output logic [1:0] b,
  output logic       hsync,
  output logic       vsync,
  output logic       csync,
  output logic [8:0] line_len
);
  localparam int DEPTH = 1 << BUF_AW;

  logic [7:0]      mem [0:2*DEPTH-1];
  logic [8:0]      hc_prev, rc;
  logic            ls_now, ls_pend, wr_ok, hs_raw, hs1;
  logic [7:0]      rd_data, pix1;
  logic [BUF_AW:0] wr_addr, rd_addr;

  generate
    if (BUF_AW >= 9) begin : g_full
      assign wr_ok = 1'b1;
    end else begin : g_clip
      assign wr_ok = ((hc_in >> BUF_AW) == 9'd0);
    end
  endgenerate

  assign ls_now  = ck7 && (hc_in == 9'd0) && (hc_prev != 9'd0);
  assign wr_addr = {even_line, BUF_AW'(hc_in)};
  assign rd_addr = {~even_line, BUF_AW'(rc)};
  assign hs_raw  = (rc >= 9'(HS_START)) && (rc < 9'(HS_START + HS_LEN));

  // Buffer has no reset; stale contents only affect the first lines after reset.
  always_ff @(posedge clk28)
    if (ck7 && wr_ok) mem[wr_addr] <= {g_in, r_in, b_in};

  always_ff @(posedge clk28 or negedge rst_n)
    if (!rst_n) rd_data <= 8'd0;
    else        rd_data <= mem[rd_addr];

  // ls_pend holds a line start seen between ck14 strobes so the resync is never lost.
  always_ff @(posedge clk28 or negedge rst_n)
    if (!rst_n) begin
      hc_prev  <= 9'd0;
      line_len <= 9'(LINE_LEN_RST);
      rc       <= 9'd0;
      ls_pend  <= 1'b0;
    end else begin
      if (ck7)    hc_prev  <= hc_in;
      if (ls_now) line_len <= hc_prev + 9'd1;
      if (ck14) begin
        ls_pend <= 1'b0;
        if (ls_pend || ls_now)         rc <= 9'd0;
        else if (rc == line_len - 9'd1) rc <= 9'd0;
        else                           rc <= rc + 9'd1;
      end else if (ls_now) begin
        ls_pend <= 1'b1;
      end
    end

  // Pipeline keeps running in bypass so doubler output is coherent as soon as en returns.
  always_ff @(posedge clk28 or negedge rst_n)
    if (!rst_n) begin
      pix1  <= 8'd0;
      hs1   <= 1'b0;
      r     <= 3'd0;
      g     <= 3'd0;
      b     <= 2'd0;
      hsync <= 1'b0;
      vsync <= 1'b0;
      csync <= 1'b1;
    end else begin
      if (ck14) begin
        pix1 <= rd_data;
        hs1  <= hs_raw;
      end
      if (!en) begin
        r     <= r_in;
        g     <= g_in;
        b     <= b_in;
        hsync <= hsync_in;
        vsync <= vsync_in;
        csync <= csync_in;
      end else if (ck14) begin
        {g, r, b} <= pix1;
        hsync     <= hs1;
        vsync     <= vsync_in;
        csync     <= ~(hs1 ^ vsync_in);
      end
    end
endmodule

// File: tb/tb_vga_scandoubler.sv
// Bench for vga_scandoubler: streaming scoreboard for doubler mode, vector table for bypass.
module tb_vga_scandoubler;
  logic       rst_n, clk28, ck7, ck14, en, even_line, hsync_in, vsync_in, csync_in;
  logic [8:0] hc_in, line_len;
  logic [2:0] r_in, g_in, r, g;
  logic [1:0] b_in, b;
  logic       hsync, vsync, csync;

  vga_scandoubler dut (
    .rst_n(rst_n), .clk28(clk28), .ck7(ck7), .ck14(ck14), .en(en),
    .hc_in(hc_in), .even_line(even_line), .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .csync_in(csync_in),
    .r(r), .g(g), .b(b), .hsync(hsync), .vsync(vsync), .csync(csync),
    .line_len(line_len)
  );

  initial begin
    clk28 = 1'b0;
    forever #5 clk28 = ~clk28;
  end

  typedef struct { logic [7:0] pix; logic hs; } exp_t;
  typedef struct {
    logic [2:0] r, g; logic [1:0] b; logic hs, vs, cs;
    logic [7:0] e_rgb; logic [2:0] e_sync;
  } vec_t;

  int   n_chk, n_fail, cyc, ln, hc, hc_max, rc_m, ll_m, hc_prev_m, vs_cnt;
  logic sb_on, byp, rst_next, ls_m;
  exp_t q[$];
  exp_t exp_next;
  vec_t tbl[6];

  function automatic logic [7:0] pat(int l, int h);
    return 8'(l * 37 + h * 5 + 3);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (line %0d cyc %0d)", nm, act, exp, ln, cyc);
    end
  endtask

  // One clk28: check the edge just taken, then drive inputs and advance the model for the next edge.
  task automatic step();
    exp_t e;
    int   prev;
    logic exp_cs;
    @(negedge clk28);
    if (ck14) begin
      if (sb_on) begin
        q.push_back(exp_next);
        if (q.size() > 2) begin
          e = q.pop_front();
          exp_cs = ~(e.hs ^ vsync_in);
          chk("pixel", {g, r, b}, e.pix);
          chk("hsync", hsync, e.hs);
          chk("vsync", vsync, vsync_in);
          chk("csync", csync, exp_cs);
        end
        if (vsync) vs_cnt++;
      end else q.delete();
    end
    rst_n = rst_next;
    cyc++;
    ck7  = (cyc % 4 == 0);
    ck14 = (cyc % 2 == 0);
    ls_m = 1'b0;
    if (ck7) begin
      hc = (hc >= hc_max) ? 0 : hc + 1;
      if (hc == 0) begin
        ln++;
        even_line = ~even_line;
      end
      hc_in = 9'(hc);
      prev  = hc_prev_m;
      if (rst_n) begin
        ls_m      = (hc == 0) && (prev != 0);
        hc_prev_m = hc;
      end
      if (ls_m) ll_m = prev + 1;
      if (!byp) begin
        {g_in, r_in, b_in} = pat(ln, hc);
        vsync_in = (ln >= 6 && ln <= 13);
      end
    end
    if (ck14 && rst_n) begin
      if (ls_m || rc_m == ll_m - 1) rc_m = 0;
      else                          rc_m++;
      exp_next.pix = pat(ln - 1, rc_m);
      exp_next.hs  = (rc_m >= 329 && rc_m < 383);
    end
  endtask

  initial begin
    tbl[0] = '{3'd7, 3'd0, 2'd0, 1'b1, 1'b0, 1'b0, 8'b000_111_00, 3'b100};
    tbl[1] = '{3'd0, 3'd7, 2'd3, 1'b0, 1'b1, 1'b1, 8'b111_000_11, 3'b011};
    tbl[2] = '{3'd5, 3'd2, 2'd1, 1'b1, 1'b1, 1'b0, 8'b010_101_01, 3'b110};
    tbl[3] = '{3'd2, 3'd5, 2'd2, 1'b0, 1'b0, 1'b1, 8'b101_010_10, 3'b001};
    tbl[4] = '{3'd3, 3'd6, 2'd0, 1'b1, 1'b0, 1'b1, 8'b110_011_00, 3'b101};
    tbl[5] = '{3'd4, 3'd1, 2'd3, 1'b0, 1'b1, 1'b0, 8'b001_100_11, 3'b010};

    n_chk = 0; n_fail = 0; cyc = 0; ln = -1; hc = 447; hc_max = 447;
    rc_m = 0; ll_m = 448; hc_prev_m = 0; vs_cnt = 0;
    sb_on = 0; byp = 0; rst_next = 1; ls_m = 0;
    exp_next = '{8'd0, 1'b0};
    rst_n = 1; en = 1; ck7 = 0; ck14 = 0; even_line = 0; hc_in = 9'd0;
    r_in = 0; g_in = 0; b_in = 0; hsync_in = 0; vsync_in = 0; csync_in = 1;

    #1 rst_n = 0;
    #1;
    chk("rst_rgb", {g, r, b}, 0);
    chk("rst_hsync", hsync, 0);
    chk("rst_vsync", vsync, 0);
    chk("rst_csync", csync, 1);
    chk("rst_line_len", line_len, 448);
    #1 rst_n = 1;

    // 48K timing, then vsync held for 8 input lines
    while (ln < 2) step();
    sb_on = 1;
    chk("line_len_48k", line_len, 448);
    while (ln < 14) step();
    hc_max = 455;
    repeat (8) step();
    chk("line_len_stale", line_len, 448);
    while (ln < 15) step();
    repeat (8) step();
    chk("line_len_128k", line_len, 456);
    while (ln < 17) step();
    sb_on = 0;
    chk("vsync_strobes", vs_cnt, 16 * 448);

    // bypass vectors: each must appear exactly one clk28 after it is driven
    byp = 1;
    for (int i = 0; i < 6; i++) begin
      en = 0;
      r_in = tbl[i].r; g_in = tbl[i].g; b_in = tbl[i].b;
      hsync_in = tbl[i].hs; vsync_in = tbl[i].vs; csync_in = tbl[i].cs;
      if (i > 0) begin
        #1;
        chk("byp_hold_rgb", {g, r, b}, tbl[i-1].e_rgb);
        chk("byp_hold_sync", {hsync, vsync, csync}, tbl[i-1].e_sync);
      end
      step();
      chk("byp_rgb", {g, r, b}, tbl[i].e_rgb);
      chk("byp_sync", {hsync, vsync, csync}, tbl[i].e_sync);
    end
    en = 1; byp = 0; hsync_in = 0; vsync_in = 0; csync_in = 1;
    while (ln < 19) step();
    sb_on = 1;
    while (ln < 21) step();
    sb_on = 0;

    // asynchronous reset in the middle of a line
    while (!(ln == 21 && rc_m == 200)) step();
    step();
    rst_n = 0; rst_next = 0;
    #1;
    chk("mid_rst_rgb", {g, r, b}, 0);
    chk("mid_rst_hsync", hsync, 0);
    chk("mid_rst_vsync", vsync, 0);
    chk("mid_rst_csync", csync, 1);
    chk("mid_rst_line_len", line_len, 448);
    rc_m = 0; ll_m = 448; hc_prev_m = 0;
    repeat (3) step();
    rst_next = 1;
    while (ln < 23) step();
    sb_on = 1;
    while (ln < 24) step();
    sb_on = 0;
    chk("line_len_after_rst", line_len, 456);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_scandoubler.md
Name: vga_scandoubler

Overview:
- Downstream stage of the screen controller. Converts the 15.6 kHz RGB 3:3:2 pixel stream into a 31 kHz VGA stream at the same colour depth.
- Writes each incoming line (7 MHz pixel rate) into one bank of a two-bank line buffer, and replays the other bank twice at 14 MHz.
- Generates its own VGA hsync and passes vsync through.
- A bypass mode forwards the native RGBS signals unchanged.

Parameters:
- BUF_AW, 9, line-buffer address width per bank; depth 2^BUF_AW pixels, must be ≥ the longest line (456).
- LINE_LEN_RST, 448, line length loaded at reset, before the first measurement.
- HS_START, 329, read-counter value at which VGA hsync asserts.
- HS_LEN, 54, VGA hsync width in 14 MHz pixels.

Ports:
- rst_n  in  1  asynchronous active-low reset
- clk28  in  1  28 MHz master clock
- ck7  in  1  7 MHz single-cycle clk28 strobe (input pixel rate)
- ck14  in  1  14 MHz single-cycle clk28 strobe (output pixel rate)
- en  in  1  1 = scandoubled VGA output, 0 = bypass
- hc_in  in  9  input horizontal pixel counter
- even_line  in  1  input line parity; selects the write bank
- r_in  in  3  input red
- g_in  in  3  input green
- b_in  in  2  input blue
- hsync_in  in  1  input hsync, active high
- vsync_in  in  1  input vsync, active high
- csync_in  in  1  input composite sync
- r  out  3  output red
- g  out  3  output green
- b  out  2  output blue
- hsync  out  1  output hsync, active high
- vsync  out  1  output vsync, active high
- csync  out  1  output composite sync
- line_len  out  9  measured input line length in pixels

Behaviour:
- Reset (async): rc=0, line_len=LINE_LEN_RST, hc_prev=0, all pipeline registers 0, r/g/b/hsync/vsync=0, csync=1. Buffer contents are undefined; garbage on the first two output lines after reset is permitted. Reset mid-line takes effect immediately with no partial-line completion.

Write side, on each ck7:
- mem[{even_line, hc_in}] <= {g_in, r_in, b_in}. hc_in ≥ 2^BUF_AW is not written.
- hc_prev <= hc_in.

Line-start event (ls), evaluated on ck7:
- ls = (hc_in == 0) && (hc_prev != 0).
- On ls: line_len <= hc_prev + 1. The new value is used from the next read wrap.

Read counter rc (9 bit), on each ck14:
- If ls occurred since the previous ck14: rc <= 0. This is the resync and has priority over wrap.
- Else if rc == line_len-1: rc <= 0. This starts the second replay of the same line.
- Else rc <= rc+1.

Read address and data:
- Read address = {~even_line, rc}, so the read bank never equals the write bank.
- rd_data registered from mem every clk28 (synchronous RAM, one-cycle latency).

Output pipeline, in doubler mode (en=1):
- Fixed 2-ck14 latency: the pixel read at rc=k appears on r/g/b two ck14 strobes later.
- hs_raw = (rc >= HS_START) && (rc < HS_START+HS_LEN), delayed identically, then drives hsync.
- vsync = vsync_in, registered on ck14.
- csync = ~(hsync ^ vsync).
- r/g/b hold between ck14 strobes.

Bypass (en=0):
- r, g, b, hsync, vsync and csync = the corresponding inputs, registered every clk28 (1-cycle delay).
- The write side and rc keep running.
- Toggling en switches on the next clk28; glitches in the current line are allowed.

Boundary conditions:
- line_len == 0 cannot occur, because hc_prev+1 for hc_prev ≠ 0. If line_len changes mid-replay, the current pass uses the new value; ls still resyncs rc.
- A line longer than 2^BUF_AW wraps the address.
- ck7 and ck14 coinciding on the same clk28 is normal: write and read proceed independently (dual-port).

Test Plan:
- 48K timing, hc_in 0..447 looping, even_line toggling per line -> line_len=448 after the first ls; rc goes 0..447 twice per input line; two hsync pulses per input line, each 54 ck14 wide, starting at rc=329.
- Input line N has pixel 10 = 8'hA5, all other pixels 0 -> during line N+1, r/g/b = {g=5, r=1, b=1} twice, each time 2 ck14 after rc=10; no write to the read bank.
- Switch hc_in wrap from 447 to 455 (128K timing) -> line_len=456 after the next ls; rc reaches 455 before wrapping; resync keeps rc=0 aligned with ls.
- vsync_in high for 8 input lines -> vsync high for 16 VGA lines; csync low during hsync XOR vsync pattern as specified.
- en=0 with input r=7, hsync_in=1 -> r=7, hsync=1 one clk28 later; en back to 1 -> doubler output resumes on the next line.
- rst_n pulsed low mid-line with rc=200 -> all outputs 0 and csync=1 immediately; line_len=448; normal output after two input lines.
